// File: rtl/div_volt_if.sv
// Request/response bundle for the div_volt sequential divider.
interface div_volt_if #(
    parameter int ASIZE = 18,
    parameter int BSIZE = 18,
    parameter int PSIZE = 36
);
    logic             in_valid;
    logic             in_ready;
    logic [PSIZE-1:0] dividend;
    logic [BSIZE-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [ASIZE-1:0] quotient;
    logic [BSIZE-1:0] remainder;
    logic             ovf;
    logic             dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dz
    );
endinterface

// File: rtl/div_volt.sv
// Radix-2 restoring signed divider (scaled product / scale factor -> saturated quotient).
// Define DIV_VOLT_ROUND_EN to round the quotient half away from zero instead of truncating.
module div_volt #(
    parameter int ASIZE = 18,
    parameter int BSIZE = 18,
    parameter int PSIZE = ASIZE + BSIZE
) (
    input  logic     clk,
    input  logic     rst_n,
    div_volt_if.slave bus
);
    localparam int CW = $clog2(PSIZE);
    localparam logic [PSIZE:0]   QLIM = (PSIZE+1)'(1) << (ASIZE-1);
    localparam logic [ASIZE-1:0] QMAX = {1'b0, {(ASIZE-1){1'b1}}};
    localparam logic [ASIZE-1:0] QMIN = {1'b1, {(ASIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [PSIZE-1:0] dvd, qmag;
    logic [BSIZE-1:0] dsr;
    logic [BSIZE:0]   rem;
    logic [PSIZE:0]   q_abs;
    logic             sign_q, sign_r, dz_r, fix_ph;
    logic [ASIZE-1:0] q_out;
    logic [BSIZE-1:0] r_out;
    logic             ovf_out, dz_out, out_vld;
    logic             ready, accept;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) state_nx = CALC;
            end
            CALC: if (cnt == CW'(PSIZE-1)) state_nx = FIX;
            FIX:  if (fix_ph) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign accept = bus.in_valid & ready;

    // ---------------- datapath ----------------
    // Unsigned negate maps the most-negative value onto its exact magnitude.
    logic [PSIZE-1:0] a_abs;
    logic [BSIZE-1:0] b_abs;
    assign a_abs = bus.dividend[PSIZE-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign b_abs = bus.divisor[BSIZE-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;

    logic [BSIZE:0] rem_sh, rem_nx;
    logic           ge;
    assign rem_sh = {rem[BSIZE-1:0], dvd[PSIZE-1]};
    assign ge     = rem_sh >= {1'b0, dsr};
    assign rem_nx = ge ? (rem_sh - {1'b0, dsr}) : rem_sh;

    logic rnd;
`ifdef DIV_VOLT_ROUND_EN
    assign rnd = !dz_r && ({rem, 1'b0} >= {2'b00, dsr});
`else
    assign rnd = 1'b0;
`endif

    // Partial remainder stays below the divisor, so its top bit only matters for rounding.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[BSIZE];

    logic             neg, pos_ovf, neg_ovf, ovf_fix;
    logic [ASIZE-1:0] q_fix;
    logic [BSIZE-1:0] r_fix, rmag;

    always_comb begin
        neg     = sign_q && (q_abs != '0);
        pos_ovf = q_abs >= QLIM;
        neg_ovf = q_abs > QLIM;
        rmag    = rem[BSIZE-1:0];
        r_fix   = dz_r ? '0 : (sign_r ? (~rmag + 1'b1) : rmag);
        ovf_fix = dz_r | (neg ? neg_ovf : pos_ovf);
        if (dz_r)      q_fix = sign_r ? QMIN : QMAX;
        else if (neg)  q_fix = neg_ovf ? QMIN : (~q_abs[ASIZE-1:0] + 1'b1);
        else           q_fix = pos_ovf ? QMAX : q_abs[ASIZE-1:0];
    end

    // FIX takes two clocks: rounding increment first, then sign/saturate into outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dvd     <= '0;
            dsr     <= '0;
            rem     <= '0;
            qmag    <= '0;
            q_abs   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_r    <= 1'b0;
            fix_ph  <= 1'b0;
            q_out   <= '0;
            r_out   <= '0;
            ovf_out <= 1'b0;
            dz_out  <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dvd    <= a_abs;
                    dsr    <= b_abs;
                    sign_q <= bus.dividend[PSIZE-1] ^ bus.divisor[BSIZE-1];
                    sign_r <= bus.dividend[PSIZE-1];
                    dz_r   <= (bus.divisor == '0);
                    cnt    <= '0;
                    rem    <= '0;
                    qmag   <= '0;
                    fix_ph <= 1'b0;
                end
                CALC: begin
                    dvd  <= {dvd[PSIZE-2:0], 1'b0};
                    rem  <= rem_nx;
                    qmag <= {qmag[PSIZE-2:0], ge};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    if (!fix_ph) begin
                        q_abs  <= {1'b0, qmag} + {{PSIZE{1'b0}}, rnd};
                        fix_ph <= 1'b1;
                    end else begin
                        fix_ph  <= 1'b0;
                        q_out   <= q_fix;
                        r_out   <= r_fix;
                        ovf_out <= ovf_fix;
                        dz_out  <= dz_r;
                        out_vld <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) out_vld <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_vld;
    assign bus.quotient  = q_out;
    assign bus.remainder = r_out;
    assign bus.ovf       = ovf_out;
    assign bus.dz        = dz_out;
endmodule

// File: tb/tb_div_volt.sv
// Directed self-checking bench for div_volt: signs, saturation, divide-by-zero, stall, reset.
module tb_div_volt;
    localparam int ASIZE = 18, BSIZE = 18, PSIZE = 36;
`ifdef DIV_VOLT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_volt_if #(.ASIZE(ASIZE), .BSIZE(BSIZE), .PSIZE(PSIZE)) bus();
    div_volt #(.ASIZE(ASIZE), .BSIZE(BSIZE), .PSIZE(PSIZE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int passed = 0, total = 0;

    typedef struct packed {
        logic signed [PSIZE-1:0] a;
        logic signed [BSIZE-1:0] b;
        logic signed [ASIZE-1:0] q;
        logic signed [BSIZE-1:0] r;
        logic ovf;
        logic dz;
    } vec_t;

    logic signed [ASIZE-1:0] q_o;
    logic signed [BSIZE-1:0] r_o;
    logic ovf_o, dz_o;
    int lat;

    task automatic do_op(input logic [PSIZE-1:0] a, input logic [BSIZE-1:0] b, input bit release_out);
        int n = 0;
        while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        q_o = bus.quotient; r_o = bus.remainder; ovf_o = bus.ovf; dz_o = bus.dz;
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.ovf, bus.dz} !== {1'b1, 1'b0, 18'd0, 18'd0, 1'b0, 1'b0})
            $display("FAIL reset: in_ready=%b out_valid=%b q=%0d r=%0d ovf=%b dz=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.ovf, bus.dz);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors(input string name, input vec_t v[], input int cnt);
        for (int i = 0; i < cnt; i++) begin
            do_op(v[i].a, v[i].b, 1'b1);
            total++;
            if ({8'(lat), q_o, r_o, ovf_o, dz_o} !== {8'd38, v[i].q, v[i].r, v[i].ovf, v[i].dz})
                $display("FAIL %s[%0d] %0d/%0d: got q=%0d r=%0d ovf=%b dz=%b lat=%0d, want q=%0d r=%0d ovf=%b dz=%b lat=38",
                         name, i, v[i].a, v[i].b, q_o, r_o, ovf_o, dz_o, lat, v[i].q, v[i].r, v[i].ovf, v[i].dz);
            else passed++;
        end
    endtask

    task automatic test_basic();
        vec_t v[] = new[4];
        v[0] = '{36'sd1000000, 18'sd250, 18'sd4000, 18'sd0, 1'b0, 1'b0};
        v[1] = '{-36'sd1000000, 18'sd250, -18'sd4000, 18'sd0, 1'b0, 1'b0};
        v[2] = '{36'sd100, 18'sd7, 18'sd14, 18'sd2, 1'b0, 1'b0};
        v[3] = '{-36'sd100, 18'sd7, -18'sd14, -18'sd2, 1'b0, 1'b0};
        test_vectors("basic", v, 4);
    endtask

    task automatic test_signs();
        vec_t v[] = new[5];
        v[0] = '{-36'sd7, 18'sd2, (RND ? -18'sd4 : -18'sd3), -18'sd1, 1'b0, 1'b0};
        v[1] = '{36'sd7, -18'sd2, (RND ? -18'sd4 : -18'sd3), 18'sd1, 1'b0, 1'b0};
        v[2] = '{-36'sd7, -18'sd2, (RND ? 18'sd4 : 18'sd3), -18'sd1, 1'b0, 1'b0};
        v[3] = '{36'sd5, 18'sd10, (RND ? 18'sd1 : 18'sd0), 18'sd5, 1'b0, 1'b0};
        v[4] = '{-36'sd3, 18'sd10, 18'sd0, -18'sd3, 1'b0, 1'b0};
        test_vectors("signs", v, 5);
    endtask

    task automatic test_saturate();
        vec_t v[] = new[8];
        v[0] = '{36'sd1073741824, 18'sd1, 18'sd131071, 18'sd0, 1'b1, 1'b0};
        v[1] = '{{1'b1, 35'd0}, 18'sd1, {1'b1, 17'd0}, 18'sd0, 1'b1, 1'b0};
        v[2] = '{36'sd131071, 18'sd1, 18'sd131071, 18'sd0, 1'b0, 1'b0};
        v[3] = '{-36'sd131072, 18'sd1, {1'b1, 17'd0}, 18'sd0, 1'b0, 1'b0};
        v[4] = '{36'sd131072, 18'sd1, 18'sd131071, 18'sd0, 1'b1, 1'b0};
        v[5] = '{-36'sd131073, 18'sd1, {1'b1, 17'd0}, 18'sd0, 1'b1, 1'b0};
        v[6] = '{{1'b1, 35'd0}, {1'b1, 17'd0}, 18'sd131071, 18'sd0, 1'b1, 1'b0};
        v[7] = '{36'sd1000, {1'b1, 17'd0}, 18'sd0, 18'sd1000, 1'b0, 1'b0};
        test_vectors("saturate", v, 8);
    endtask

    task automatic test_div_zero();
        vec_t v[] = new[3];
        v[0] = '{36'sd123, 18'sd0, 18'sd131071, 18'sd0, 1'b1, 1'b1};
        v[1] = '{-36'sd5, 18'sd0, {1'b1, 17'd0}, 18'sd0, 1'b1, 1'b1};
        v[2] = '{36'sd0, 18'sd0, 18'sd131071, 18'sd0, 1'b1, 1'b1};
        test_vectors("div_zero", v, 3);
    endtask

    task automatic test_stall();
        do_op(36'sd1000000, -18'sd250, 1'b0);
        total++;
        if ({8'(lat), q_o, ovf_o} !== {8'd38, -18'sd4000, 1'b0})
            $display("FAIL stall_result: got q=%0d ovf=%b lat=%0d, want q=-4000 ovf=0 lat=38", q_o, ovf_o, lat);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.ovf, bus.dz} !== {1'b1, 1'b0, -18'sd4000, 18'sd0, 1'b0, 1'b0})
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b q=%0d r=%0d, want 1 0 -4000 0",
                         i, bus.out_valid, bus.in_ready, $signed(bus.quotient), $signed(bus.remainder));
            else passed++;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0)
            $display("FAIL stall_release_cycle: in_ready=%b, want 0", bus.in_ready);
        else passed++;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL stall_after: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        else passed++;
    endtask

    task automatic test_reset_midop();
        bus.dividend = 36'sd1000000;
        bus.divisor  = 18'sd250;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.ovf, bus.dz} !== {1'b1, 1'b0, 18'd0, 18'd0, 1'b0, 1'b0})
            $display("FAIL midop_reset: in_ready=%b out_valid=%b q=%0d r=%0d ovf=%b dz=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.ovf, bus.dz);
        else passed++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(36'sd7, -18'sd2, 1'b1);
        total++;
        if ({8'(lat), q_o, r_o, ovf_o, dz_o} !== {8'd38, (RND ? -18'sd4 : -18'sd3), 18'sd1, 1'b0, 1'b0})
            $display("FAIL midop_fresh: got q=%0d r=%0d ovf=%b dz=%b lat=%0d, want q=%0d r=1 ovf=0 dz=0 lat=38",
                     q_o, r_o, ovf_o, dz_o, lat, (RND ? -4 : -3));
        else passed++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_signs();
        test_saturate();
        test_div_zero();
        test_stall();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
